// File: rtl/lsb_four_approximate_rc_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsb_four_approximate_rc_adder_pkg
// Description : Shared defaults for the approximate ripple-carry adder.
//               It holds the operand width and the number of approximated
//               LSBs. It also holds the derived width of the exact upper part.
// Revision    : 1.0 - initial release
// ============================================================================
package lsb_four_approximate_rc_adder_pkg;

    localparam int c_WIDTH_DEFAULT       = 8;
    localparam int c_APPROX_BITS_DEFAULT = 4;
    localparam int c_UPPER_WIDTH_DEFAULT = c_WIDTH_DEFAULT - c_APPROX_BITS_DEFAULT;

endpackage : lsb_four_approximate_rc_adder_pkg
`default_nettype wire

// File: rtl/lsb_four_approximate_rc_adder_full_adder.sv
`default_nettype none
// ============================================================================
// Module      : lsb_four_approximate_rc_adder_full_adder
// Description : Single-bit exact full adder. It is used for the upper part
//               of the approximate adder.
//   a, b  in  1  addend bits
//   cin   in  1  carry in
//   s     out 1  sum bit
//   cout  out 1  carry out (majority of a, b, cin)
// Revision    : 1.0 - initial release
// ============================================================================
module lsb_four_approximate_rc_adder_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : lsb_four_approximate_rc_adder_full_adder
`default_nettype wire

// File: rtl/lsb_four_approximate_rc_adder.sv
`default_nettype none
// ============================================================================
// Module      : lsb_four_approximate_rc_adder
// Description : Registered approximate ripple-carry adder.
//               - The low APPROX_BITS bits are the bitwise OR of the operands.
//               - The upper bits use an exact ripple chain. Its carry-in is
//                 generated from the top approximated bit pair.
//               - The result is registered. Reset is asynchronous and
//                 active-high.
//   clk   in  1      rising-edge clock
//   rst   in  1      asynchronous active-high reset (clears S and Cout)
//   A     in  WIDTH  operand A, unsigned
//   B     in  WIDTH  operand B, unsigned
//   Cin   in  1      carry-in, kept for interface compatibility; ignored
//   S     out WIDTH  registered approximate sum
//   Cout  out 1      registered carry-out of the MSB
// Revision    : 1.0 - initial release
// ============================================================================
module lsb_four_approximate_rc_adder
    import lsb_four_approximate_rc_adder_pkg::*;
#(
    parameter int WIDTH       = c_WIDTH_DEFAULT,
    parameter int APPROX_BITS = c_APPROX_BITS_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    localparam int c_UPPER = WIDTH - APPROX_BITS;

    logic [WIDTH-1:0] w_sum;
    // w_carry[j] is the carry into bit APPROX_BITS+j.
    logic [c_UPPER:0] w_carry;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;

    // Cin does not enter the datapath. The name keeps it out of unused-signal reports.
    logic w_unused;
    assign w_unused = Cin;

    // The low part has no carry chain. Bit APPROX_BITS-1 still produces the
    // single generated carry that feeds the exact upper part.
    genvar gi;
    generate
        for (gi = 0; gi < APPROX_BITS; gi++) begin : g_low_or
            assign w_sum[gi] = A[gi] | B[gi];
        end
    endgenerate

    assign w_carry[0] = A[APPROX_BITS-1] & B[APPROX_BITS-1];

    generate
        for (gi = 0; gi < c_UPPER; gi++) begin : g_upper_fa
            lsb_four_approximate_rc_adder_full_adder u_full_adder (
                .a    (A[APPROX_BITS+gi]),
                .b    (B[APPROX_BITS+gi]),
                .cin  (w_carry[gi]),
                .s    (w_sum[APPROX_BITS+gi]),
                .cout (w_carry[gi+1])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s    <= '0;
            r_cout <= 1'b0;
        end else begin
            r_s    <= w_sum;
            r_cout <= w_carry[c_UPPER];
        end
    end

    assign S    = r_s;
    assign Cout = r_cout;

endmodule : lsb_four_approximate_rc_adder
`default_nettype wire

// File: tb/tb_lsb_four_approximate_rc_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsb_four_approximate_rc_adder
// Description : Self-checking bench for lsb_four_approximate_rc_adder.
//               It applies directed vectors with hand-computed results, then
//               sweeps all operand pairs against an arithmetic reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsb_four_approximate_rc_adder;

    logic       clk;
    logic       rst;
    logic [7:0] A;
    logic [7:0] B;
    logic       Cin;
    logic [7:0] S;
    logic       Cout;

    int n_vec = 0;
    int n_err = 0;

    lsb_four_approximate_rc_adder #(
        .WIDTH       (8),
        .APPROX_BITS (4)
    ) u_dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
        .Cin  (Cin),
        .S    (S),
        .Cout (Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model in arithmetic form. The low nibble is an OR. The upper
    // nibble is an exact add plus the carry generated by bit 3.
    function automatic logic [8:0] ref_sum(input logic [7:0] a, input logic [7:0] b);
        logic [4:0] up;
        up = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'b0, a[3] & b[3]};
        return {up, a[3:0] | b[3:0]};
    endfunction

    // The inputs change at the falling edge. The result is sampled just after the next rising edge.
    task automatic apply(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic [8:0] exp);
        @(negedge clk);
        A   = a;
        B   = b;
        Cin = cin;
        @(posedge clk);
        #1;
        check(tag, {Cout, S}, exp);
    endtask

    initial begin
        logic [7:0] pa;
        logic [7:0] pb;
        rst = 1'b0;
        A   = 8'hFF;
        B   = 8'hFF;
        Cin = 1'b0;

        // Reset clears the outputs before any clock edge.
        #1 rst = 1'b1;
        #1 check("reset_async", {Cout, S}, 9'd0);
        @(posedge clk); #1 check("reset_hold0", {Cout, S}, 9'd0);
        @(posedge clk); #1 check("reset_hold1", {Cout, S}, 9'd0);

        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1 check("ff_ff", {Cout, S}, 9'd511);

        // Reset asserted mid-cycle clears the result at once.
        #2 rst = 1'b1;
        #1 check("reset_midcycle", {Cout, S}, 9'd0);
        @(negedge clk) rst = 1'b0;

        apply("zero",      8'd0,   8'd0,   1'b0, 9'd0);
        apply("exact_300", 8'd200, 8'd100, 1'b0, 9'd300);
        apply("exact_15",  8'd5,   8'd10,  1'b0, 9'd15);

        // An input change after the edge leaves the registered result unchanged.
        A = 8'd200;
        #1 check("input_midcycle", {Cout, S}, 9'd15);

        apply("approx_15_1", 8'd15,  8'd1,   1'b0, 9'd15);
        apply("approx_ff",   8'd255, 8'd255, 1'b0, 9'd511);
        // The OR keeps bit 3 set. The generated carry adds 16, so the result is 24.
        apply("approx_8_8",  8'd8,   8'd8,   1'b0, 9'd24);
        apply("approx_7_7",  8'd7,   8'd7,   1'b0, 9'd7);
        apply("cin0",        8'd100, 8'd27,  1'b0, 9'd127);
        apply("cin1",        8'd100, 8'd27,  1'b1, 9'd127);

        // Exhaustive sweep, one pair per clock. Each check looks at the pair driven one cycle earlier.
        Cin = 1'b0;
        pa  = '0;
        pb  = '0;
        for (int k = 0; k <= 65536; k++) begin
            @(negedge clk);
            if (k > 0) begin
                $display("%0d + %0d -> %0d", pa, pb, {Cout, S});
                check("sweep", {Cout, S}, ref_sum(pa, pb));
            end
            if (k < 65536) begin
                pa = k[15:8];
                pb = k[7:0];
                A  = pa;
                B  = pb;
                Cin = k[0];
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_lsb_four_approximate_rc_adder
`default_nettype wire
